// File: rtl/pid_pwm_driver.sv
// pid_pwm_driver: turns the PID controller's 8-bit control word into a
// single-bit PWM drive. Control words are double-buffered in a pending
// register and applied only at period boundaries. An enable/drain FSM
// guarantees that a started period always runs to completion.
// Optional feature macro: PWM_SLEW_EN limits the duty change per period
// to SLEW_STEP. When it is left undefined, no slew logic is built.
module pid_pwm_driver #(
    parameter int PRESCALE  = 4,
    parameter int SLEW_STEP = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] control_in,
    input  logic       control_valid,
    input  logic       enable,
    output logic       pwm_out,
    output logic       period_start,
    output logic [7:0] duty_active,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [7:0]    CNT_LAST = 8'd254;

    // Reject parameter values that cannot describe a valid PWM period or step.
    if (PRESCALE < 1 || SLEW_STEP < 1 || SLEW_STEP > 255) begin : g_param_check
        $error("pid_pwm_driver: PRESCALE must be >= 1 and SLEW_STEP in 1..255");
    end

`ifdef PWM_SLEW_EN
    // Move cur toward tgt by at most SLEW_STEP. The 9-bit arithmetic cannot
    // wrap because the result is clamped at the target.
    function automatic logic [7:0] slew_limit(input logic [7:0] cur,
                                              input logic [7:0] tgt);
        logic [8:0] c9;
        logic [8:0] t9;
        logic [8:0] s9;
        logic [8:0] r9;
        c9 = {1'b0, cur};
        t9 = {1'b0, tgt};
        s9 = 9'(SLEW_STEP);
        if (t9 > c9) begin
            if ((t9 - c9) > s9) begin
                r9 = c9 + s9;
            end else begin
                r9 = t9;
            end
        end else if (c9 > t9) begin
            if ((c9 - t9) > s9) begin
                r9 = c9 - s9;
            end else begin
                r9 = t9;
            end
        end else begin
            r9 = t9;
        end
        return r9[7:0];
    endfunction
`endif

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    pending_q, pending_d;
    logic [7:0]    duty_q, duty_d;
    logic          pwm_q, pwm_d;
    logic          pstart_q, pstart_d;
    logic          busy_q, busy_d;

    logic          tick_s;
    logic          boundary_s;
    logic [PW-1:0] pre_adv_s;
    logic [7:0]    cnt_adv_s;
    logic [7:0]    next_duty_s;

    assign tick_s     = (pre_q == PRE_LAST);
    assign boundary_s = tick_s && (cnt_q == CNT_LAST);

`ifdef PWM_SLEW_EN
    assign next_duty_s = slew_limit(duty_q, pending_q);
`else
    assign next_duty_s = pending_q;
`endif

    // Free-running advance of the prescaler and the 255-tick period counter.
    always_comb begin
        pre_adv_s = pre_q;
        cnt_adv_s = cnt_q;
        if (tick_s) begin
            pre_adv_s = '0;
            if (cnt_q == CNT_LAST) begin
                cnt_adv_s = 8'd0;
            end else begin
                cnt_adv_s = cnt_q + 8'd1;
            end
        end else begin
            pre_adv_s = pre_q + PW'(1);
        end
    end

    // Next-state logic: FSM transitions, counters, duty load and output values.
    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        cnt_d     = cnt_q;
        duty_d    = duty_q;
        pstart_d  = 1'b0;
        pending_d = pending_q;
        if (control_valid) begin
            pending_d = control_in;
        end else begin
            pending_d = pending_q;
        end
        case (state_q)
            ST_IDLE: begin
                pre_d  = '0;
                cnt_d  = 8'd0;
                duty_d = 8'd0;
                if (enable) begin
                    state_d  = ST_RUN;
                    duty_d   = next_duty_s;
                    pstart_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                pre_d = pre_adv_s;
                cnt_d = cnt_adv_s;
                if (boundary_s) begin
                    duty_d   = next_duty_s;
                    pstart_d = 1'b1;
                end else begin
                    duty_d = duty_q;
                end
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pre_d = pre_adv_s;
                cnt_d = cnt_adv_s;
                if (boundary_s) begin
                    if (enable) begin
                        state_d  = ST_RUN;
                        duty_d   = next_duty_s;
                        pstart_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        duty_d  = 8'd0;
                        pre_d   = '0;
                        cnt_d   = 8'd0;
                    end
                end else if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                pre_d   = '0;
                cnt_d   = 8'd0;
                duty_d  = 8'd0;
            end
        endcase
        // Outputs are registered from the next-state values, so they appear
        // in the cycle right after the edge that changes the state.
        busy_d = (state_d != ST_IDLE);
        pwm_d  = (state_d != ST_IDLE) && (cnt_d < duty_d);
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pre_q     <= '0;
            cnt_q     <= 8'd0;
            pending_q <= 8'd0;
            duty_q    <= 8'd0;
            pwm_q     <= 1'b0;
            pstart_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            duty_q    <= duty_d;
            pwm_q     <= pwm_d;
            pstart_q  <= pstart_d;
            busy_q    <= busy_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = pstart_q;
    assign duty_active  = duty_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Directed bench for pid_pwm_driver at PRESCALE=4 (1020 clk per period).
// Expected high counts are duty*4 clocks per period.
module tb_pid_pwm_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] control_in;
    logic       control_valid;
    logic       enable;
    logic       pwm_out;
    logic       period_start;
    logic [7:0] duty_active;
    logic       busy;

    int total = 0;
    int bad   = 0;

    pid_pwm_driver #(.PRESCALE(4), .SLEW_STEP(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .control_in   (control_in),
        .control_valid(control_valid),
        .enable       (enable),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .duty_active  (duty_active),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n cycles counting pwm high and period_start cycles; any
    // control_valid pulse set before the call lasts for exactly one edge.
    task automatic run(input int n, output int highs, output int starts);
        highs  = 0;
        starts = 0;
        for (int i = 0; i < n; i++) begin
            highs  += int'(pwm_out);
            starts += int'(period_start);
            step();
            control_valid = 1'b0;
        end
    endtask

    initial begin
        int h;
        int s;
        int h2;
        int s2;
        int h3;
        int s3;
        rst           = 1'b1;
        control_in    = 8'd0;
        control_valid = 1'b0;
        enable        = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_pstart", int'(period_start), 0);
        check("rst_duty", int'(duty_active), 0);
        check("rst_busy", int'(busy), 0);

`ifdef PWM_SLEW_EN
        control_in = 8'd200; control_valid = 1'b1;
        run(1, h, s);
        enable = 1'b1;
        run(1, h, s);
        for (int k = 0; k < 13; k++) begin
            check("slew_up", int'(duty_active), (16 * (k + 1) > 200) ? 200 : 16 * (k + 1));
            if (k == 12) begin
                control_in = 8'd0; control_valid = 1'b1;
            end
            run(1020, h, s);
        end
        for (int k = 0; k < 13; k++) begin
            check("slew_down", int'(duty_active), (184 - 16 * k < 0) ? 0 : 184 - 16 * k);
            run(1020, h, s);
        end
`else
        // Baseline duty 64
        control_in = 8'd64; control_valid = 1'b1;
        run(1, h, s);
        check("idle_busy", int'(busy), 0);
        check("idle_duty", int'(duty_active), 0);
        enable = 1'b1;
        run(1, h, s);
        check("en_busy", int'(busy), 1);
        check("en_duty", int'(duty_active), 64);
        check("en_pstart", int'(period_start), 1);
        check("en_pwm", int'(pwm_out), 1);
        run(1020, h, s);
        check("p1_high", h, 256);
        check("p1_starts", s, 1);
        check("p2_pstart", int'(period_start), 1);

        // Extremes: duty 0 for two periods, then 255 for two periods
        control_in = 8'd0; control_valid = 1'b1;
        run(1020, h, s);
        check("p2_high", h, 256);
        check("p3_duty", int'(duty_active), 0);
        run(1020, h, s);
        check("p3_high", h, 0);
        control_in = 8'd255; control_valid = 1'b1;
        run(1020, h, s);
        check("p4_high", h, 0);
        check("p5_duty", int'(duty_active), 255);
        run(1020, h, s);
        check("p5_high", h, 1020);
        check("p6_pwm_at_boundary", int'(pwm_out), 1);
        check("p6_pstart", int'(period_start), 1);
        control_in = 8'd50; control_valid = 1'b1;
        run(1020, h, s);
        check("p6_high", h, 1020);

        // Mid-period update at cnt=100
        check("p7_duty", int'(duty_active), 50);
        run(400, h, s);
        control_in = 8'd150; control_valid = 1'b1;
        run(620, h2, s2);
        check("p7_high", h + h2, 200);
        check("p8_duty", int'(duty_active), 150);
        run(1020, h, s);
        check("p8_high", h, 600);

        // Drain: enable drops at cnt=30, period completes, then IDLE
        run(120, h, s);
        enable = 1'b0;
        run(1, h2, s2);
        check("drain_busy", int'(busy), 1);
        run(899, h3, s3);
        check("drain_high", h + h2 + h3, 600);
        check("drain_end_busy", int'(busy), 0);
        check("drain_end_pwm", int'(pwm_out), 0);
        check("drain_end_duty", int'(duty_active), 0);
        check("drain_end_pstart", int'(period_start), 0);

        // Re-enable at cnt=200 while draining
        enable = 1'b1;
        run(1, h, s);
        check("ren_pstart", int'(period_start), 1);
        check("ren_duty", int'(duty_active), 150);
        run(120, h, s);
        enable = 1'b0;
        run(680, h2, s2);
        check("ren_drain_busy", int'(busy), 1);
        enable = 1'b1;
        run(220, h3, s3);
        check("ren_high", h + h2 + h3, 600);
        check("ren_starts", s + s2 + s3, 1);
        check("ren_next_pstart", int'(period_start), 1);
        check("ren_next_busy", int'(busy), 1);

        // Reset mid-operation at cnt=10 with pwm high
        run(40, h, s);
        check("pre_rst_pwm", int'(pwm_out), 1);
        rst = 1'b1;
        run(1, h, s);
        rst = 1'b0;
        check("mrst_pwm", int'(pwm_out), 0);
        check("mrst_pstart", int'(period_start), 0);
        check("mrst_duty", int'(duty_active), 0);
        check("mrst_busy", int'(busy), 0);
        run(1, h, s);
        check("mrst_restart_busy", int'(busy), 1);
        check("mrst_pending_cleared", int'(duty_active), 0);
        check("mrst_restart_pwm", int'(pwm_out), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pid_pwm_driver.md
# pid_pwm_driver

Output stage directly downstream of the PID controller: takes the 8-bit control word the controller drives on its output pins and turns it into a single-bit PWM drive for the plant actuator. New control words are double-buffered and applied only at period boundaries, so each PWM period is glitch-free. An optional slew limiter bounds the duty-cycle change per period. An enable/drain state machine ensures the output never stops mid-period.

## Interface
Parameters:
- PRESCALE, 4: clk cycles per PWM tick (≥1)
- SLEW_STEP, 16: max duty change per period when slew limiting is compiled in (1..255)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high, sampled on rising clk edge
- control_in  input  8  duty request from PID controller output (unsigned, 0..255)
- control_valid  input  1  one-cycle strobe: capture control_in into pending register
- enable  input  1  level: run PWM while high
- pwm_out  output  1  PWM drive
- period_start  output  1  one-cycle pulse on first clk of every PWM period
- duty_active  output  8  duty in force for the current period
- busy  output  1  high in RUN or DRAIN

## Operation
- Registers: state, pre (prescaler 0..PRESCALE-1), cnt (0..254), pending[7:0], duty_active[7:0].
- tick = (pre == PRESCALE-1); pre increments every clk outside IDLE and wraps to 0 on tick. cnt increments on tick and wraps 254→0 (255 ticks per period).
- boundary = tick && cnt == 254.
- pending <= control_in on any clk with control_valid=1, in any state; last write wins.
- next_duty: without slew, = pending. With slew, = duty_active moved toward pending by min(|pending − duty_active|, SLEW_STEP). Arithmetic is 9-bit, with no wrap past 0 or 255.
- pwm_out = (state != IDLE) && (cnt < duty_active).
  - duty 0: pwm_out never high.
  - duty 255: pwm_out continuously high, including across boundaries.
- FSM:
  - IDLE:
    - pre, cnt, duty_active held at 0.
    - enable=1 → RUN. On that edge, duty_active <= next_duty (computed from duty_active=0); pre, cnt <= 0.
  - RUN:
    - boundary → duty_active <= next_duty.
    - enable=0 → DRAIN, with counters continuing.
  - DRAIN:
    - counting and PWM continue unchanged.
    - enable=1 → RUN, with no gap.
    - boundary with enable=0 → IDLE, duty_active <= 0.
    - boundary with enable=1 → RUN, duty_active <= next_duty.
- Simultaneous control_valid and boundary: next_duty uses pending before the edge. The new value applies one period later.

## Timing
- Reset values: pwm_out=0, period_start=0, duty_active=0, busy=0, state=IDLE, pending=0.
- Period length = 255 × PRESCALE clk cycles (1020 at default).
- period_start is high in the first clk after entering RUN from IDLE, and in the first clk after each boundary while not going to IDLE.
- enable→pwm latency: enable sampled high at edge N. busy, duty_active and pwm_out change in the cycle after edge N.
- Duty-update latency: a control_valid at any point in period P takes effect at the start of period P+1.
- Reset mid-operation: outputs return to reset values in the cycle after the rst edge; pending is cleared.
- rst has priority over every other input.

## Configuration
- PWM_SLEW_EN defined: slew limiter active as described; duty_active changes by at most SLEW_STEP per boundary, including the first load from IDLE.
- PWM_SLEW_EN undefined: next_duty = pending; SLEW_STEP is unused; no slew logic is synthesized.

## Test plan
- Baseline, no slew, PRESCALE=4:
  - Stimulus: reset; control_in=64 with valid; enable=1.
  - Response: pwm_out high 256 clk, low 764 clk per period. period_start every 1020 clk. busy=1.
- Extremes:
  - Stimulus: duty 0 for two periods, then 255 for two periods.
  - Response: pwm_out constant 0 through the duty-0 periods. Once 255 applies, pwm_out stays constant 1 across the boundary.
- Slew, PWM_SLEW_EN:
  - Stimulus: from IDLE, pending=200, enable=1.
  - Response: duty_active per period = 16, 32, …, 192, 200 (13 periods).
  - Stimulus: then control_in=0.
  - Response: duty steps down by 16 each period, reaching 0 after 13 periods.
- Mid-period update:
  - Stimulus: duty 50 running; control_in=150 valid at cnt=100.
  - Response: current period keeps 50 high ticks; next period has 150.
- Drain:
  - Stimulus: enable=0 at cnt=30.
  - Response: period completes. At boundary busy=0, pwm_out=0, duty_active=0.
  - Stimulus: separately, re-enable at cnt=200 during DRAIN.
  - Response: no gap; next period_start on schedule.
- Reset mid-operation:
  - Stimulus: rst=1 for one cycle while pwm_out=1 at cnt=10.
  - Response: next cycle all outputs 0, state IDLE, pending 0.
